// File: rtl/qs_fifo_push_arb.sv
// Round-robin push arbiter in front of a qs_fifo write port.
// A credit counter of free slots makes sure a registered push never meets a full FIFO.
module qs_fifo_push_arb #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int NREQ   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ*DATA_W-1:0]     req_data_i,
  output logic [NREQ-1:0]            ack_o,
  output logic                       push_o,
  output logic [DATA_W-1:0]          push_data_o,
  input  logic                       fifo_pop_i,
  input  logic                       fifo_full_i,
  output logic [$clog2(DEPTH+1)-1:0] credit_o,
  output logic                       err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     r_rr_ptr;
  logic [CW-1:0]     r_credit;
  logic              r_push;
  logic [DATA_W-1:0] r_push_data;
  logic              r_err;

  logic              w_found;
  logic [PW-1:0]     w_winner;
  logic              w_issue;
  logic [NREQ-1:0]   w_ack;
  logic [CW:0]       w_credit_sum;
  logic [CW-1:0]     w_credit_d;
  logic              w_pop_at_full;

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_found && req_i[(int'(r_rr_ptr) + i) % NREQ]) begin
        w_found  = 1'b1;
        w_winner = PW'((int'(r_rr_ptr) + i) % NREQ);
      end
    end
  end

  assign w_issue = (|req_i) && (r_credit != '0) && !reset;

  always_comb begin
    w_ack = '0;
    if (w_issue) w_ack = NREQ'(1) << w_winner;
  end

  assign w_pop_at_full = fifo_pop_i && (r_credit == CW'(DEPTH));

  // Issue only happens with credit > 0, so the sum cannot underflow.
  assign w_credit_sum = {1'b0, r_credit} + (CW+1)'(fifo_pop_i) - (CW+1)'(w_issue);

  always_comb begin
    w_credit_d = w_credit_sum[CW-1:0];
    if (w_credit_sum > (CW+1)'(DEPTH)) w_credit_d = CW'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_credit    <= CW'(DEPTH);
      r_rr_ptr    <= PW'(NREQ - 1);
      r_err       <= 1'b0;
    end else begin
      r_push   <= w_issue;
      r_credit <= w_credit_d;
      if (w_issue) begin
        r_push_data <= req_data_i[w_winner*DATA_W +: DATA_W];
        r_rr_ptr    <= w_winner;
      end
      if ((r_push && fifo_full_i) || w_pop_at_full) r_err <= 1'b1;
    end
  end

  assign ack_o       = w_ack;
  assign push_o      = r_push;
  assign push_data_o = r_push_data;
  assign credit_o    = r_credit;
  assign err_o       = r_err;

endmodule

// File: tb/tb_qs_fifo_push_arb.sv
// Bench for qs_fifo_push_arb: scripted requester traffic, a FIFO occupancy model
// driving fifo_full_i, and a queue of expected push data checked at the output.
module tb_qs_fifo_push_arb;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int NREQ   = 3;
  localparam int CW     = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_i;
  logic [NREQ*DATA_W-1:0] req_data_i;
  logic [NREQ-1:0]        ack_o;
  logic                   push_o;
  logic [DATA_W-1:0]      push_data_o;
  logic                   fifo_pop_i;
  logic                   fifo_full_i;
  logic [CW-1:0]          credit_o;
  logic                   err_o;

  int n_chk  = 0;
  int n_pass = 0;
  int fifo_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  qs_fifo_push_arb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NREQ(NREQ)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .req_data_i  (req_data_i),
    .ack_o       (ack_o),
    .push_o      (push_o),
    .push_data_o (push_data_o),
    .fifo_pop_i  (fifo_pop_i),
    .fifo_full_i (fifo_full_i),
    .credit_o    (credit_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Occupancy of the downstream FIFO as seen by the arbiter.
  always @(posedge clk) begin
    int nxt;
    if (reset) fifo_cnt <= 0;
    else begin
      nxt = fifo_cnt + (push_o ? 1 : 0) - (fifo_pop_i ? 1 : 0);
      if (nxt < 0) nxt = 0;
      if (nxt > DEPTH) nxt = DEPTH;
      fifo_cnt <= nxt;
    end
  end
  assign fifo_full_i = (fifo_cnt == DEPTH);

  always @(negedge clk) begin
    if (!reset && push_o) begin
      if (exp_q.size() == 0) chk("push_unexpected", 32'(push_data_o), 32'hxxxx_dead);
      else chk("push_data", 32'(push_data_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    req_data_i = {d2, d1, d0};
  endtask

  // Check the grant for this cycle; a grant adds the winner's data to the scoreboard.
  task automatic exp_ack(input string tag, input logic [NREQ-1:0] e);
    logic [NREQ*DATA_W-1:0] d;
    #1;
    chk(tag, 32'(ack_o), 32'(e));
    d = req_data_i;
    for (int k = 0; k < NREQ; k++)
      if (e[k]) exp_q.push_back(d[k*DATA_W +: DATA_W]);
  endtask

  task automatic do_reset;
    reset      = 1'b1;
    req_i      = '0;
    fifo_pop_i = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req_i      = '1;
    fifo_pop_i = 1'b0;
    set_data(8'h10, 8'h11, 8'h12);
    cyc();
    cyc();
    #1;
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_push", 32'(push_o), 0);
    chk("rst_credit", 32'(credit_o), DEPTH);
    chk("rst_err", 32'(err_o), 0);

    // single requester
    reset = 1'b0;
    req_i = 3'b001;
    set_data(8'hAB, 8'h00, 8'h00);
    exp_ack("single_ack", 3'b001);
    cyc();
    req_i = '0;
    chk("single_push", 32'(push_o), 1);
    chk("single_credit", 32'(credit_o), 1);
    cyc();
    cyc();

    // round-robin with a pop every cycle from t+1
    do_reset();
    req_i = 3'b111;
    set_data(8'hA0, 8'hA1, 8'hA2);
    exp_ack("rr0", 3'b001);
    cyc();
    fifo_pop_i = 1'b1;
    exp_ack("rr1", 3'b010);
    cyc();
    exp_ack("rr2", 3'b100);
    cyc();
    exp_ack("rr3", 3'b001);
    cyc();
    req_i      = '0;
    fifo_pop_i = 1'b0;
    cyc();
    cyc();

    // credit exhaustion, then one pop returns one credit
    do_reset();
    req_i = 3'b010;
    set_data(8'h00, 8'hC1, 8'h00);
    exp_ack("ex0", 3'b010);
    cyc();
    set_data(8'h00, 8'hC2, 8'h00);
    exp_ack("ex1", 3'b010);
    cyc();
    exp_ack("ex2", 3'b000);
    chk("ex_credit0", 32'(credit_o), 0);
    cyc();
    exp_ack("ex3", 3'b000);
    chk("ex_full", 32'(fifo_full_i), 1);
    chk("ex_err", 32'(err_o), 0);
    fifo_pop_i = 1'b1;
    exp_ack("ex_pop_cycle", 3'b000);
    cyc();
    fifo_pop_i = 1'b0;
    set_data(8'h00, 8'hC3, 8'h00);
    exp_ack("ex_after_pop", 3'b010);
    cyc();
    exp_ack("ex_only_one", 3'b000);
    chk("ex_credit_again", 32'(credit_o), 0);
    req_i = '0;
    cyc();
    chk("ex_err_after", 32'(err_o), 0);
    cyc();

    // simultaneous issue and pop at credit 1
    do_reset();
    req_i = 3'b001;
    set_data(8'hD1, 8'h00, 8'h00);
    exp_ack("sp0", 3'b001);
    cyc();
    req_i = '0;
    cyc();
    chk("sp_credit_before", 32'(credit_o), 1);
    req_i      = 3'b001;
    fifo_pop_i = 1'b1;
    set_data(8'hD2, 8'h00, 8'h00);
    exp_ack("sp1", 3'b001);
    cyc();
    fifo_pop_i = 1'b0;
    chk("sp_credit_same", 32'(credit_o), 1);
    set_data(8'hD3, 8'h00, 8'h00);
    exp_ack("sp2", 3'b001);
    cyc();
    req_i = '0;
    chk("sp_credit_end", 32'(credit_o), 0);
    chk("sp_err", 32'(err_o), 0);
    cyc();
    cyc();

    // reset mid-burst with a push pending and no credit
    do_reset();
    req_i = 3'b111;
    set_data(8'hE0, 8'hE1, 8'hE2);
    exp_ack("mb0", 3'b001);
    cyc();
    exp_ack("mb1", 3'b010);
    cyc();
    exp_ack("mb2", 3'b000);
    chk("mb_credit0", 32'(credit_o), 0);
    chk("mb_pending", 32'(push_o), 1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mb_ack_in_reset", 32'(ack_o), 0);
    cyc();
    chk("mb_push_cleared", 32'(push_o), 0);
    chk("mb_credit_restored", 32'(credit_o), DEPTH);
    reset = 1'b0;
    exp_ack("mb_restart", 3'b001);
    cyc();
    req_i = '0;
    cyc();
    cyc();

    // pop at full credit is a consumer bug: sticky error, credit saturates
    do_reset();
    fifo_pop_i = 1'b1;
    cyc();
    fifo_pop_i = 1'b0;
    chk("bug_err", 32'(err_o), 1);
    chk("bug_credit_sat", 32'(credit_o), DEPTH);
    cyc();
    chk("bug_err_sticky", 32'(err_o), 1);
    do_reset();
    #1;
    chk("bug_err_cleared", 32'(err_o), 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
